// File: rtl/imem_align.sv
// -----------------------------------------------------------------------------
// imem_align
//   Two-entry line buffer that assembles a 64-bit big-endian instruction window
//   starting at any halfword-aligned fetch address. A window can straddle two
//   8-byte memory lines (A = addr_in[63:3], B = A + 1). Missing lines are
//   fetched one at a time from memory; the window is presented combinationally
//   once every needed line is resident.
//
// Ports
//   clk             sole clock, rising edge
//   rst             asynchronous active-high reset
//   addr_in         fetch byte address (halfword aligned)
//   addr_valid_in   addr_in is meaningful this cycle
//   data_out        8-byte window at addr_in, byte addr_in in bits 63:56
//   data_valid_out  data_out is correct for the current addr_in
//   misalign_out    addr_valid_in with addr_in[0] set
//   flush           invalidate both line entries
//   mem_addr        line address of the outstanding read (bits 2:0 zero)
//   mem_req         line read request, held until mem_ack
//   mem_ack         completes the outstanding read; mem_rdata valid
//   mem_rdata       line data, big-endian
// -----------------------------------------------------------------------------
module imem_align (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr_in,
  input  logic        addr_valid_in,
  output logic [63:0] data_out,
  output logic        data_valid_out,
  output logic        misalign_out,
  input  logic        flush,
  output logic [63:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        valid_q, valid_d;
  logic [1:0][60:0]  tag_q, tag_d;
  logic [1:0][63:0]  data_q, data_d;
  logic              lru_q, lru_d;
  logic [60:0]       target_q, target_d;
  logic              victim_q, victim_d;
  logic              mem_req_q, mem_req_d;
  logic [63:0]       mem_addr_q, mem_addr_d;

  logic [2:0]        off_s;
  logic [60:0]       line_a_s;
  logic [60:0]       line_b_s;
  logic [1:0]        a_in_s;
  logic [1:0]        b_in_s;
  logic              need_b_s;
  logic              hit_s;
  logic [63:0]       data_a_s;
  logic [63:0]       data_b_s;
  logic [127:0]      window_s;
  logic              miss_start_s;
  logic [60:0]       target_s;
  logic [1:0]        keep_s;
  logic              victim_s;

  // Lookup of both needed lines against the two entries and window assembly.
  always_comb begin
    off_s    = addr_in[2:0];
    line_a_s = addr_in[63:3];
    // 61-bit add wraps from all-ones back to line 0.
    line_b_s = addr_in[63:3] + 61'd1;
    for (int i = 0; i < 2; i++) begin
      a_in_s[i] = valid_q[i] & (tag_q[i] == line_a_s);
      b_in_s[i] = valid_q[i] & (tag_q[i] == line_b_s);
    end
    need_b_s = (off_s != 3'd0);
    hit_s    = (|a_in_s) & (~need_b_s | (|b_in_s));
    data_a_s = a_in_s[0] ? data_q[0] : data_q[1];
    data_b_s = b_in_s[0] ? data_q[0] : data_q[1];
    // Shift the byte at offset off up to the top of the 16-byte pair.
    window_s = {data_a_s, data_b_s} << {off_s, 3'b000};
  end

  // Choice of the missing line to fetch and of the entry it will replace.
  always_comb begin
    target_s = (|a_in_s) ? line_b_s : line_a_s;
    // keep_s marks an entry holding the other line this window still needs.
    if (|a_in_s) begin
      keep_s = a_in_s;
    end else if (need_b_s) begin
      keep_s = b_in_s;
    end else begin
      keep_s = 2'b00;
    end
    if (keep_s == 2'b01) begin
      victim_s = 1'b1;
    end else if (keep_s == 2'b10) begin
      victim_s = 1'b0;
    end else if (!valid_q[0]) begin
      victim_s = 1'b0;
    end else if (!valid_q[1]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_q;
    end
    miss_start_s = addr_valid_in & ~hit_s & ~addr_in[0] & ~flush;
  end

  // Refill FSM next-state, entry updates and request outputs.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    lru_d      = lru_q;
    target_d   = target_q;
    victim_d   = victim_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_start_s) begin
          state_d    = ST_REQ;
          target_d   = target_s;
          victim_d   = victim_s;
          mem_req_d  = 1'b1;
          mem_addr_d = {target_s, 3'b000};
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (flush) begin
          // The returning line may predate the flush, so it is never kept.
          if (mem_ack) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d   = ST_DISCARD;
          end
        end else if (mem_ack) begin
          valid_d[victim_q] = 1'b1;
          tag_d[victim_q]   = target_q;
          data_d[victim_q]  = mem_rdata;
          lru_d             = ~victim_q;
          state_d           = ST_IDLE;
          mem_req_d         = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d   = ST_DISCARD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    if (flush) begin
      valid_d = 2'b00;
    end else begin
      valid_d = valid_d;
    end
  end

  // State, entry and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      valid_q    <= 2'b00;
      tag_q      <= '0;
      data_q     <= '0;
      lru_q      <= 1'b0;
      target_q   <= 61'd0;
      victim_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      lru_q      <= lru_d;
      target_q   <= target_d;
      victim_q   <= victim_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign data_out       = window_s[127:64];
  assign data_valid_out = addr_valid_in & hit_s & ~addr_in[0] & ~flush;
  assign misalign_out   = addr_valid_in & addr_in[0];
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_imem_align.sv
// -----------------------------------------------------------------------------
// tb_imem_align
//   Scoreboard bench for imem_align. Fetch stimulus pushes the expected window
//   (built byte by byte from a memory model) into a queue; a monitor pops and
//   compares on every cycle that data_valid_out is high. A memory responder
//   answers line requests with model data after a configurable delay.
// -----------------------------------------------------------------------------
module tb_imem_align;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr_in;
  logic        addr_valid_in;
  logic [63:0] data_out;
  logic        data_valid_out;
  logic        misalign_out;
  logic        flush;
  logic [63:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] req_log[$];
  int          fixed_delay = 2;
  bit          resp_en = 1'b1;
  int          stray_cnt = 0;
  int          stray_done = 0;

  imem_align dut (
    .clk            (clk),
    .rst            (rst),
    .addr_in        (addr_in),
    .addr_valid_in  (addr_valid_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .misalign_out   (misalign_out),
    .flush          (flush),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: two fixed lines, everything else a hash of the line number.
  function automatic logic [63:0] line_data(input logic [60:0] l);
    if (l == 61'h200) return 64'h1122334455667788;
    else if (l == 61'h201) return 64'hAABBCCDDEEFF0011;
    else return {l[31:0] ^ 32'h9E3779B9, l[60:29] + 32'h7F4A7C15};
  endfunction

  // Expected window: the eight consecutive bytes at a (64-bit address wrap).
  function automatic logic [63:0] window(input logic [63:0] a);
    logic [63:0] r;
    logic [63:0] b;
    logic [63:0] ld;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      b  = a + 64'(i);
      ld = line_data(b[63:3]);
      r[8*(7-i) +: 8] = ld[8*(7-int'(b[2:0])) +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory responder.
  initial begin
    int d;
    mem_ack   = 1'b0;
    mem_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      if (stray_cnt != stray_done) begin
        mem_ack   = 1'b1;
        mem_rdata = 64'hDEADBEEFDEADBEEF;
        stray_done++;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
      end else if (resp_en && mem_req && !rst) begin
        req_log.push_back(mem_addr);
        chk("mem_addr_low_bits", {61'd0, mem_addr[2:0]}, 64'd0);
        d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = line_data(mem_addr[63:3]);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (data_valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid addr=%h data_out=%h", addr_in, data_out);
        end else begin
          e = exp_q.pop_front();
          chk("window", data_out, e);
        end
      end
    end
  end

  task automatic fetch(input logic [63:0] a, input bit rand_flush, output int waited);
    bit got;
    @(posedge clk); #1;
    addr_in       = a;
    addr_valid_in = 1'b1;
    flush         = 1'b0;
    exp_q.push_back(window(a));
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 300) begin
      @(negedge clk);
      if (data_valid_out) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        flush = rand_flush && ($urandom_range(0, 19) == 0);
        waited++;
      end
    end
    flush = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout addr=%h waited=%0d", a, waited);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    addr_valid_in = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_mem_req(input string name);
    int k;
    k = 0;
    while (!mem_req && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, {63'd0, mem_req}, 64'd1);
  endtask

  // Main stimulus.
  initial begin
    int w;
    int k;
    logic [63:0] a;
    logic [63:0] mask;
    mask          = ~64'd1;
    rst           = 1'b1;
    addr_in       = 64'h1000;
    addr_valid_in = 1'b0;
    flush         = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_valid", {63'd0, data_valid_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single aligned line, memory answers two cycles after the request.
    fixed_delay = 2;
    req_log.delete();
    fetch(64'h1000, 1'b0, w);
    chk("single_req_count", 64'(req_log.size()), 64'd1);
    if (req_log.size() > 0) chk("single_req_addr", req_log[0], 64'h1000);
    chk("single_data", data_out, 64'h1122334455667788);

    // Cold two-line window.
    go_idle();
    pulse_flush();
    req_log.delete();
    fetch(64'h1006, 1'b0, w);
    chk("two_line_req_count", 64'(req_log.size()), 64'd2);
    if (req_log.size() == 2) begin
      chk("two_line_req0", req_log[0], 64'h1000);
      chk("two_line_req1", req_log[1], 64'h1008);
    end
    chk("two_line_data", data_out, 64'h7788AABBCCDDEEFF);

    // Stepping through resident lines: valid every cycle, no requests.
    req_log.delete();
    for (int i = 0; i < 3; i++) begin
      fetch(64'h1000 + 64'(2 * i), 1'b0, w);
      chk("step_wait_cycles", 64'(w), 64'd0);
    end
    chk("step_req_count", 64'(req_log.size()), 64'd0);

    // Misaligned address.
    go_idle();
    req_log.delete();
    @(posedge clk); #1;
    addr_in       = 64'h1003;
    addr_valid_in = 1'b1;
    @(negedge clk);
    chk("misalign_flag", {63'd0, misalign_out}, 64'd1);
    chk("misalign_valid", {63'd0, data_valid_out}, 64'd0);
    repeat (3) @(negedge clk);
    chk("misalign_no_req", {63'd0, mem_req}, 64'd0);
    chk("misalign_req_count", 64'(req_log.size()), 64'd0);
    go_idle();

    // Replacement order: least-recently-filled entry is evicted.
    pulse_flush();
    fetch(64'h5000, 1'b0, w);
    fetch(64'h6000, 1'b0, w);
    fetch(64'h7000, 1'b0, w);
    req_log.delete();
    fetch(64'h6000, 1'b0, w);
    chk("lru_keep_wait", 64'(w), 64'd0);
    fetch(64'h5000, 1'b0, w);
    chk("lru_evict_req_count", 64'(req_log.size()), 64'd1);

    // Flush during an outstanding request.
    go_idle();
    fixed_delay = 3;
    req_log.delete();
    @(posedge clk); #1;
    addr_in       = 64'h2000;
    addr_valid_in = 1'b1;
    exp_q.push_back(window(64'h2000));
    wait_mem_req("flush_req_seen");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_req_held", {63'd0, mem_req}, 64'd1);
    k = 0;
    while (!data_valid_out && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("flush_refetch_valid", {63'd0, data_valid_out}, 64'd1);
    chk("flush_req_count", 64'(req_log.size()), 64'd2);
    if (req_log.size() == 2) chk("flush_req1_addr", req_log[1], 64'h2000);
    if (!data_valid_out) void'(exp_q.pop_back());

    // Window across the top of the address space.
    fixed_delay = 1;
    req_log.delete();
    fetch(64'hFFFFFFFFFFFFFFFA, 1'b0, w);
    chk("wrap_req_count", 64'(req_log.size()), 64'd2);
    if (req_log.size() == 2) begin
      chk("wrap_req0", req_log[0], 64'hFFFFFFFFFFFFFFF8);
      chk("wrap_req1", req_log[1], 64'h0);
    end

    // Reset in the middle of a request, then a stray ack.
    go_idle();
    resp_en = 1'b0;
    @(posedge clk); #1;
    addr_in       = 64'h3000;
    addr_valid_in = 1'b1;
    wait_mem_req("rst_req_seen");
    #2;
    rst = 1'b1;
    addr_valid_in = 1'b0;
    #1;
    chk("rst_async_req", {63'd0, mem_req}, 64'd0);
    chk("rst_async_addr", mem_addr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stray_cnt++;
    repeat (4) @(negedge clk);
    chk("stray_ack_no_req", {63'd0, mem_req}, 64'd0);
    resp_en     = 1'b1;
    fixed_delay = 0;
    req_log.delete();
    fetch(64'h3000, 1'b0, w);
    chk("after_rst_req_count", 64'(req_log.size()), 64'd1);

    // Randomized fetches with random memory latency and occasional flushes.
    fixed_delay = -1;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k < 6) a = 64'h4000 + 64'(2 * $urandom_range(0, 31));
      else if (k < 8) a = {$urandom, $urandom} & mask;
      else a = 64'hFFFFFFFFFFFFFFF0 + 64'(2 * $urandom_range(0, 7));
      fetch(a, 1'b1, w);
    end

    go_idle();
    repeat (8) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_align.md
IMEM_ALIGN -- requirements
Module: imem_align

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port addr_in  input  64  fetch byte address, halfword-aligned, from the fetch stage.
REQ-004 SHALL have port addr_valid_in  input  1  addr_in is meaningful this cycle.
REQ-005 SHALL have port data_out  output  64  64-bit instruction window starting at addr_in, big-endian (byte addr_in in bits 63:56).
REQ-006 SHALL have port data_valid_out  output  1  data_out is correct for the current addr_in.
REQ-007 SHALL have port misalign_out  output  1  addr_valid_in high with addr_in[0]=1.
REQ-008 SHALL have port flush  input  1  invalidate both line entries.
REQ-009 SHALL have port mem_addr  output  64  aligned memory line address, bits 2:0 always 0.
REQ-010 SHALL have port mem_req  output  1  line read request.
REQ-011 SHALL have port mem_ack  input  1  mem_rdata valid; completes the request.
REQ-012 SHALL have port mem_rdata  input  64  line data, big-endian.

Function
REQ-013 SHALL hold two line entries E0/E1, each {valid, tag[60:0], data[63:0]}, plus one lru bit naming the least-recently-filled entry.
REQ-014 SHALL define off=addr_in[2:0], line A=addr_in[63:3], line B=A+1 (61-bit, wraps to 0 at all-ones); B is needed only when off!=0.
REQ-015 SHALL compute hit = A present in a valid entry AND (off==0 OR B present); combinational from addr_in and entry state.
REQ-016 SHALL drive data_out = bits [127-8*off -: 64] of {dataA, dataB} (dataB treated as don't-care when off==0), combinational.
REQ-017 SHALL assert data_valid_out = addr_valid_in & hit & ~addr_in[0] & ~flush; data_out is don't-care when low.
REQ-018 SHALL assert misalign_out combinationally; a misaligned address never triggers a memory request.
REQ-019 SHALL implement FSM states IDLE, REQ, DISCARD.
REQ-020 IDLE: on addr_valid_in & ~hit & ~addr_in[0] & ~flush, SHALL latch target = A if A missing else B, select victim, go REQ; mem_req rises the next cycle (registered).
REQ-021 Victim SHALL be the entry not holding the other needed line; if both qualify, an invalid entry first (E0 before E1), else the lru entry.
REQ-022 REQ: SHALL hold mem_req=1 and mem_addr={target,3'b000} stable until mem_ack; on mem_ack SHALL write tag/data/valid into victim, set lru to the other entry, go IDLE (mem_req low the cycle after ack).
REQ-023 A two-line miss SHALL be served as two sequential requests (A then B), each via IDLE re-evaluation.
REQ-024 addr_in changes during REQ SHALL NOT abort the request; IDLE re-evaluates against the new address after the fill.
REQ-025 flush SHALL clear both valid bits at the clock edge; flush in REQ SHALL go DISCARD, which keeps mem_req high until mem_ack, drops the data, returns to IDLE.
REQ-026 flush and mem_ack in the same REQ cycle SHALL drop the data (flush wins) and go IDLE.
REQ-027 Only one request SHALL be outstanding; mem_ack outside REQ/DISCARD SHALL be ignored.

Reset
REQ-028 rst high SHALL asynchronously force IDLE, both valid bits 0, lru=0, mem_req=0, mem_addr=0; data_valid_out=0 follows.
REQ-029 rst mid-request SHALL abandon the request; a later stray mem_ack SHALL be ignored.

Verification
REQ-030 After reset, addr_in=0x1000 valid, memory acks 2 cycles after req with 0x1122334455667788 -> one request to 0x1000, then data_out=0x1122334455667788, data_valid_out=1.
REQ-031 Lines 0x1000=0x1122334455667788, 0x1008=0xAABBCCDDEEFF0011, addr_in=0x1006 cold -> requests 0x1000 then 0x1008, then data_out=0x7788AABBCCDDEEFF.
REQ-032 Both lines resident, step addr_in 0x1000->0x1002->0x1004 -> data_valid_out=1 every cycle, mem_req never asserted.
REQ-033 addr_in=0x1003 valid -> misalign_out=1, data_valid_out=0, no mem_req.
REQ-034 flush asserted during REQ for 0x2000 -> mem_req held until ack, data dropped, next access to 0x2000 re-requests it.
REQ-035 addr_in=0xFFFFFFFFFFFFFFFA -> requests 0xFFFFFFFFFFFFFFF8 then 0x0000000000000000, window assembled across the wrap.
